// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider, 2W/W -> W quotient + W remainder, one quotient bit per clock.
// Latency W+1 cycles from accept to out_valid (1 cycle for overflow when SEQDIV_FAST_OVF_EN is defined).
// Backpressure: DONE holds results stable until out_ready; in_ready stays low from accept to handshake.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               overflow,
    output logic               busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   shq_q, shq_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   remo_q, remo_d;
    logic               ovfo_q, ovfo_d;

    logic [WIDTH:0]     trial;
    logic               trial_ge;
    logic [WIDTH-1:0]   trial_sub;
    logic [WIDTH-1:0]   next_rem;
    logic [WIDTH-1:0]   next_shq;
    logic               acc_ovf;

    // Upper half >= divisor means the quotient cannot fit; also catches divide-by-zero.
    assign acc_ovf = (dividend[2*WIDTH-1:WIDTH] >= divisor);

    // When the trial succeeds the difference is below the divisor, so the low W bits are exact.
    assign trial     = {rem_q, shq_q[WIDTH-1]};
    assign trial_ge  = (trial >= {1'b0, dvs_q});
    assign trial_sub = trial[WIDTH-1:0] - dvs_q;
    assign next_rem  = trial_ge ? trial_sub : trial[WIDTH-1:0];
    assign next_shq  = {shq_q[WIDTH-2:0], trial_ge};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        shq_d   = shq_q;
        dvs_d   = dvs_q;
        ovf_d   = ovf_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        ovfo_d  = ovfo_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvs_d = divisor;
                    rem_d = dividend[2*WIDTH-1:WIDTH];
                    shq_d = dividend[WIDTH-1:0];
                    cnt_d = '0;
                    ovf_d = acc_ovf;
`ifdef SEQDIV_FAST_OVF_EN
                    if (acc_ovf) begin
                        state_d = DONE;
                        quot_d  = {WIDTH{1'b1}};
                        remo_d  = '0;
                        ovfo_d  = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
`else
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                rem_d = next_rem;
                shq_d = next_shq;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    ovfo_d  = ovf_q;
                    quot_d  = ovf_q ? {WIDTH{1'b1}} : next_shq;
                    remo_d  = ovf_q ? '0 : next_rem;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            shq_q   <= '0;
            dvs_q   <= '0;
            ovf_q   <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            ovfo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            shq_q   <= shq_d;
            dvs_q   <= dvs_d;
            ovf_q   <= ovf_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            ovfo_q  <= ovfo_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign quotient  = quot_q;
    assign remainder = remo_q;
    assign overflow  = ovfo_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and random-vector bench for seq_restoring_divider at WIDTH=8.
module tb_seq_restoring_divider;

    localparam int W = 8;
`ifdef SEQDIV_FAST_OVF_EN
    localparam int OVF_LAT = 1;
`else
    localparam int OVF_LAT = W + 1;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           overflow;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, count edges until out_valid (first edge is the accept edge).
    task automatic launch(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs, output int lat);
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        lat = 0;
        while (lat < 40) begin
            tick();
            lat++;
            in_valid = 1'b0;
            if (out_valid) break;
        end
    endtask

    task automatic run_op(input string tag, input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic eo,
                          input int exp_lat);
        int lat;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        launch(dvd, dvs, lat);
        if (exp_lat > 0) check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".result"}, {15'd0, eo, er, eq}, {15'd0, overflow, remainder, quotient});
        tick();
    endtask

    initial begin
        logic [W-1:0]   hq, hr, hq2, hr2;
        logic           ho;
        logic [2*W-1:0] rd;
        logic [W-1:0]   rq, rs, rr;
        int             lat;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        #12;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.result", {15'd0, overflow, remainder, quotient}, 32'd0);
        rst = 1'b0;
        tick();
        check("reset.in_ready", 32'(in_ready), 32'd1);

        // 100 / 7 = 14 rem 2
        run_op("div100by7", 16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, W + 1);
        check("after_hs.in_ready", 32'(in_ready), 32'd1);
        // Largest non-overflow case: 65279 / 255 = 255 rem 254
        run_op("max_nonovf", 16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, W + 1);
        run_op("div_by_zero", 16'h0012, 8'h00, 8'hFF, 8'h00, 1'b1, OVF_LAT);
        run_op("hi_eq_dvs", 16'h0500, 8'h05, 8'hFF, 8'h00, 1'b1, OVF_LAT);
        run_op("small", 16'h00FF, 8'h10, 8'h0F, 8'h0F, 1'b0, W + 1);

        // Backpressure: hold DONE for 5 cycles while in_valid pulses with other operands.
        out_ready = 1'b0;
        launch(16'h03E8, 8'h21, lat);
        check("bp.latency", 32'(lat), 32'(W + 1));
        hq = quotient;
        hr = remainder;
        ho = overflow;
        check("bp.result", {15'd0, ho, hr, hq}, {15'd0, 1'b0, 8'h0A, 8'h1E});
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            dividend = 16'h0101;
            divisor  = 8'h03;
            tick();
            check("bp.hold_valid", 32'(out_valid), 32'd1);
            check("bp.hold_in_ready", 32'(in_ready), 32'd0);
            check("bp.hold_result", {15'd0, overflow, remainder, quotient}, {15'd0, 1'b0, 8'h0A, 8'h1E});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp.release_valid", 32'(out_valid), 32'd0);
        check("bp.release_in_ready", 32'(in_ready), 32'd1);
        check("bp.idle_result", {15'd0, overflow, remainder, quotient}, {15'd0, 1'b0, 8'h0A, 8'h1E});

        // Reset in CALC cycle 4 aborts the operation.
        dividend = 16'h1234;
        divisor  = 8'h56;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("abort.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort.out_valid", 32'(out_valid), 32'd0);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.result", {15'd0, overflow, remainder, quotient}, 32'd0);
        #2;
        rst = 1'b0;
        tick();
        check("abort.in_ready", 32'(in_ready), 32'd1);
        hq2 = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            hq2 = hq2 | {7'd0, out_valid};
        end
        check("abort.no_stale_valid", 32'(hq2), 32'd0);
        run_op("post_reset", 16'h0100, 8'h10, 8'h10, 8'h00, 1'b0, W + 1);

        // Random non-overflow pairs built from a chosen quotient and remainder.
        hr2 = '0;
        for (int i = 0; i < 1000; i++) begin
            rs = 8'($urandom_range(1, 255));
            rq = 8'($urandom_range(0, 255));
            rr = 8'($urandom_range(0, int'(rs) - 1));
            rd = 16'(rq) * 16'(rs) + 16'(rr);
            launch(rd, rs, lat);
            check("rand.result", {15'd0, overflow, remainder, quotient}, {15'd0, 1'b0, rr, rq});
            check("rand.identity", 32'(16'(quotient) * 16'(rs) + 16'(remainder)), 32'(rd));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
